// File: rtl/cache_way_store_if.sv
// Bus bundle for one cache way: CPU/fill write side and combinational read side.
interface cache_way_store_if #(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX
);
  localparam int unsigned LINE_W = 8 << S_OFFSET;

  logic [31:0]       addr;
  logic              cpu_write;
  logic [31:0]       wdata;
  logic [3:0]        byte_en;
  logic              fill;
  logic [LINE_W-1:0] fill_data;
  logic              dirty_set;
  logic [31:0]       rdata;
  logic [LINE_W-1:0] line_out;
  logic [S_TAG-1:0]  tag_out;
  logic              valid_out;
  logic              dirty_out;
  logic              hit;

  modport master (
    output addr, cpu_write, wdata, byte_en, fill, fill_data, dirty_set,
    input  rdata, line_out, tag_out, valid_out, dirty_out, hit
  );

  modport slave (
    input  addr, cpu_write, wdata, byte_en, fill, fill_data, dirty_set,
    output rdata, line_out, tag_out, valid_out, dirty_out, hit
  );
endinterface

// File: rtl/cache_way_store.sv
// Single cache way: data/tag/valid/dirty arrays, combinational read, clocked write.
// Optional macro CACHE_WAY_STORE_FWD_EN bypasses the pending write onto the outputs.
module cache_way_store #(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX
) (
  input  logic             clk,
  input  logic             reset_n,
  cache_way_store_if.slave bus
);
  localparam int unsigned N_SETS  = 1 << S_INDEX;
  localparam int unsigned LINE_B  = 1 << S_OFFSET;
  localparam int unsigned LINE_W  = 8 * LINE_B;
  localparam int unsigned N_WORDS = LINE_B / 4;
  localparam int unsigned WSEL_W  = S_OFFSET - 2;

  logic [LINE_W-1:0] data_q [N_SETS];
  logic [S_TAG-1:0]  tag_q  [N_SETS];
  logic [N_SETS-1:0] valid_q;
  logic [N_SETS-1:0] dirty_q;

  logic [S_INDEX-1:0] idx;
  logic [WSEL_W-1:0]  wsel;
  logic [S_TAG-1:0]   atag;
  logic               unused_addr;

  assign idx         = bus.addr[S_OFFSET +: S_INDEX];
  assign wsel        = bus.addr[2 +: WSEL_W];
  assign atag        = bus.addr[31 -: S_TAG];
  assign unused_addr = ^bus.addr[1:0];

  logic [LINE_B-1:0] byte_mask;
  logic [LINE_W-1:0] wdata_rep;
  logic [LINE_W-1:0] line_cur;
  logic [LINE_W-1:0] line_wr;

  assign byte_mask = LINE_B'(bus.byte_en) << {wsel, 2'b00};
  assign wdata_rep = {N_WORDS{bus.wdata}};
  assign line_cur  = data_q[idx];

  // Byte-granular merge of the replicated CPU word into the stored line
  always_comb begin
    line_wr = line_cur;
    for (int b = 0; b < int'(LINE_B); b++) begin
      if (byte_mask[b]) line_wr[8*b +: 8] = wdata_rep[8*b +: 8];
    end
  end

  logic [LINE_W-1:0] line_d;
  logic [S_TAG-1:0]  tag_d;
  logic              valid_d;
  logic              dirty_d;
  logic              we;

  // Fill has priority over cpu_write and always leaves the line clean
  always_comb begin
    line_d  = line_cur;
    tag_d   = tag_q[idx];
    valid_d = valid_q[idx];
    dirty_d = dirty_q[idx];
    if (bus.fill) begin
      line_d  = bus.fill_data;
      tag_d   = atag;
      valid_d = 1'b1;
      dirty_d = 1'b0;
    end else begin
      if (bus.cpu_write) line_d  = line_wr;
      if (bus.dirty_set) dirty_d = 1'b1;
    end
  end

  assign we = bus.fill | bus.cpu_write | bus.dirty_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_SETS); i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      data_q[idx]  <= line_d;
      tag_q[idx]   <= tag_d;
      valid_q[idx] <= valid_d;
      dirty_q[idx] <= dirty_d;
    end
  end

  logic [LINE_W-1:0] line_o;
  logic [S_TAG-1:0]  tag_o;
  logic              valid_o;
  logic              dirty_o;

`ifdef CACHE_WAY_STORE_FWD_EN
  // Bypass is masked while reset is held so outputs stay at zero
  assign line_o  = reset_n ? line_d  : '0;
  assign tag_o   = reset_n ? tag_d   : '0;
  assign valid_o = reset_n & valid_d;
  assign dirty_o = reset_n & dirty_d;
`else
  assign line_o  = line_cur;
  assign tag_o   = tag_q[idx];
  assign valid_o = valid_q[idx];
  assign dirty_o = dirty_q[idx];
`endif

  assign bus.line_out  = line_o;
  assign bus.rdata     = line_o[{wsel, 5'b00000} +: 32];
  assign bus.tag_out   = tag_o;
  assign bus.valid_out = valid_o;
  assign bus.dirty_out = dirty_o;
  assign bus.hit       = valid_o & (tag_o == atag);
endmodule

// File: tb/tb_cache_way_store.sv
// Directed and random checks of cache_way_store against a byte-array reference model.
module tb_cache_way_store;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_way_store_if bus ();
  cache_way_store dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [7:0]  m_data  [8][32];
  logic [23:0] m_tag   [8];
  logic        m_valid [8];
  logic        m_dirty [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      for (int b = 0; b < 32; b++) m_data[s][b] = 8'h00;
      m_tag[s] = '0; m_valid[s] = 1'b0; m_dirty[s] = 1'b0;
    end
  endtask

  function automatic logic [255:0] m_line(input int s);
    logic [255:0] l;
    for (int b = 0; b < 32; b++) l[8*b +: 8] = m_data[s][b];
    return l;
  endfunction

  task automatic idle_inputs();
    bus.cpu_write = 1'b0; bus.fill = 1'b0; bus.dirty_set = 1'b0;
    bus.byte_en = 4'b0; bus.wdata = '0; bus.fill_data = '0;
  endtask

  // Compare every output against the model for one address, inputs idle
  task automatic check_read(input logic [31:0] a);
    int s;
    int w;
    logic [255:0] l;
    bus.addr = a;
    #1;
    s = int'(a[7:5]);
    w = int'(a[4:2]);
    l = m_line(s);
    check("rdata",     bus.rdata,     l[32*w +: 32]);
    check("line_out",  bus.line_out,  l);
    check("tag_out",   bus.tag_out,   m_tag[s]);
    check("valid_out", bus.valid_out, m_valid[s]);
    check("dirty_out", bus.dirty_out, m_dirty[s]);
    check("hit",       bus.hit,       m_valid[s] && (m_tag[s] == a[31:8]));
  endtask

  task automatic do_op(input logic f, input logic cw, input logic ds, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic [255:0] fd);
    int s;
    int w;
    bus.fill = f; bus.cpu_write = cw; bus.dirty_set = ds; bus.addr = a;
    bus.wdata = wd; bus.byte_en = be; bus.fill_data = fd;
    @(posedge clk);
    s = int'(a[7:5]);
    w = int'(a[4:2]);
    if (f) begin
      for (int b = 0; b < 32; b++) m_data[s][b] = fd[8*b +: 8];
      m_tag[s] = a[31:8]; m_valid[s] = 1'b1; m_dirty[s] = 1'b0;
    end else begin
      if (cw) for (int i = 0; i < 4; i++) if (be[i]) m_data[s][4*w + i] = wd[8*i +: 8];
      if (ds) m_dirty[s] = 1'b1;
    end
    #1;
    idle_inputs();
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] fd;
    logic [31:0]  a;
    logic [23:0]  t;
    logic [2:0]   si;
    idle_inputs();
    bus.addr = 32'h0000_0040;
    model_clear();

    #3;
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_hit",   bus.hit,       1'b0);
    check_read(32'h0000_0040);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_read(32'h0000_0040);

    for (int k = 0; k < 8; k++) fd[32*k +: 32] = 32'h1111_1111 * k;
    do_op(1'b1, 1'b0, 1'b0, 32'h1234_5660, '0, 4'b0, fd);
    bus.addr = 32'h1234_5668; #1;
    check("fill_hit",   bus.hit,     1'b1);
    check("fill_tag",   bus.tag_out, 24'h123456);
    check("fill_rdata", bus.rdata,   32'h2222_2222);
    check_read(32'h1234_5668);

    do_op(1'b0, 1'b1, 1'b0, 32'h1234_5664, 32'hAABB_CCDD, 4'b0101, '0);
    bus.addr = 32'h1234_5664; #1;
    check("pw_rdata", bus.rdata,     32'h11BB_11DD);
    check("pw_dirty", bus.dirty_out, 1'b0);
    check_read(32'h1234_5664);

    do_op(1'b0, 1'b1, 1'b0, 32'h1234_5664, 32'hFFFF_FFFF, 4'b0000, '0);
    check_read(32'h1234_5664);

    do_op(1'b0, 1'b0, 1'b1, 32'h1234_5660, '0, 4'b0, '0);
    bus.addr = 32'h1234_5660; #1;
    check("ds_dirty", bus.dirty_out, 1'b1);

    fd = rand_line();
    do_op(1'b1, 1'b0, 1'b1, 32'hABCD_EF60, '0, 4'b0, fd);
    bus.addr = 32'hABCD_EF60; #1;
    check("refill_dirty", bus.dirty_out, 1'b0);
    check("refill_valid", bus.valid_out, 1'b1);
    check_read(32'hABCD_EF60);

    fd = rand_line();
    do_op(1'b1, 1'b1, 1'b1, 32'h1234_56A8, 32'hDEAD_BEEF, 4'b1111, fd);
    bus.addr = 32'h1234_56A8; #1;
    check("fill_wins_line", bus.line_out, fd);
    check_read(32'h1234_56A8);

    for (int n = 0; n < 300; n++) begin
      t  = ($urandom_range(0, 1) == 0) ? 24'h123456 : 24'hABCDEF;
      si = 3'($urandom_range(0, 7));
      a  = {t, si, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_op(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            a, $urandom, 4'($urandom_range(0, 15)), rand_line());
      t  = ($urandom_range(0, 1) == 0) ? 24'h123456 : 24'hABCDEF;
      check_read({t, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00});
    end

    for (int i = 0; i < 4; i++)
      do_op(1'b1, 1'b0, 1'b1, {24'h123456, 3'(i), 5'b0}, '0, 4'b0, rand_line());
    @(posedge clk); #3;
    bus.fill = 1'b1; bus.addr = 32'h1234_5620; bus.fill_data = rand_line();
    reset_n = 1'b0;
    #1;
    check("midrst_valid", bus.valid_out, 1'b0);
    check("midrst_hit",   bus.hit,       1'b0);
    check("midrst_line",  bus.line_out,  256'b0);
    idle_inputs();
    #1;
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) check_read({24'h123456, 3'(i), 5'b0});

`ifdef CACHE_WAY_STORE_FWD_EN
    @(negedge clk);
    bus.fill = 1'b1; bus.addr = 32'h1234_56E0; bus.fill_data = rand_line();
    #1;
    check("fwd_hit", bus.hit, 1'b1);
    idle_inputs();
`endif

    fd = rand_line();
    do_op(1'b1, 1'b0, 1'b0, 32'h1234_5640, '0, 4'b0, fd);
    check_read(32'h1234_5644);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_way_store.md
CACHE_WAY_STORE -- requirements
Module: cache_way_store

Interface
REQ-001 SHALL have parameter S_OFFSET, default 5, log2 of line bytes (32-byte line, 256 bits).
REQ-002 SHALL have parameter S_INDEX, default 3, log2 of set count (8 sets).
REQ-003 SHALL have parameter S_TAG, default 32-S_OFFSET-S_INDEX (24), tag width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 addr  in  32  byte address; tag=addr[31:8], index=addr[7:5], word=addr[4:2].
REQ-007 cpu_write  in  1  partial-line write of wdata under byte_en.
REQ-008 wdata  in  32  CPU write word.
REQ-009 byte_en  in  4  CPU byte enables; bit i enables wdata[8i+7:8i].
REQ-010 fill  in  1  whole-line write of fill_data; also sets valid=1, tag=addr tag, dirty=0.
REQ-011 fill_data  in  256  line from memory.
REQ-012 dirty_set  in  1  sets dirty bit of indexed set.
REQ-013 rdata  out  32  addressed word of indexed line.
REQ-014 line_out  out  256  full indexed line.
REQ-015 tag_out  out  S_TAG  stored tag of indexed set.
REQ-016 valid_out  out  1  stored valid bit.
REQ-017 dirty_out  out  1  stored dirty bit.
REQ-018 hit  out  1  valid_out AND (tag_out == addr[31:8]).

Function
REQ-019 Data, tag, valid and dirty storage SHALL each hold 2**S_INDEX entries, all indexed by addr[7:5].
REQ-020 Reads SHALL be combinational from addr; writes SHALL take effect at the rising clk edge and appear on outputs in the following cycle.
REQ-021 Write-enable expansion SHALL produce a 32-bit byte mask equal to byte_en shifted left by 4*addr[4:2].
REQ-022 Write data expansion SHALL replicate wdata 8 times across 256 bits.
REQ-023 rdata SHALL equal line_out[32*addr[4:2]+31 : 32*addr[4:2]].
REQ-024 cpu_write SHALL update only bytes selected by the expanded mask; other bytes unchanged.
REQ-025 fill SHALL write all 32 bytes of the line, set valid=1, store addr tag, clear dirty.
REQ-026 fill and cpu_write in the same cycle: fill SHALL win; cpu_write ignored.
REQ-027 fill and dirty_set in the same cycle: dirty SHALL end at 0.
REQ-028 cpu_write SHALL NOT alter tag, valid or dirty; the caller uses dirty_set.
REQ-029 cpu_write with byte_en=0000 SHALL leave storage unchanged.
REQ-030 Inputs idle: all storage SHALL hold its value indefinitely.

Reset
REQ-031 reset_n low SHALL immediately clear all valid, dirty, tag and data entries to 0, independent of clk.
REQ-032 During reset, outputs SHALL read 0 and hit SHALL be 0.
REQ-033 Writes coincident with reset assertion SHALL be discarded.
REQ-034 Operation SHALL resume on the first rising edge after reset_n goes high.

Configuration
REQ-035 Macro CACHE_WAY_STORE_FWD_EN defined: same-cycle bypass SHALL apply.
- Outputs reflect the pending write combinationally: fill, cpu_write merge, dirty_set.
REQ-036 Macro undefined: outputs SHALL show stored contents only (REQ-020).

Verification
REQ-037 After reset, addr=0x0000_0040 -> valid_out=0, hit=0, dirty_out=0, rdata=0.
REQ-038 Fill sequence:
- fill=1, addr=0x1234_5660, fill_data word k = 0x1111_1111*k (k=0..7).
- Next cycle addr=0x1234_5668 -> hit=1, tag_out=0x123456, rdata=0x2222_2222.
REQ-039 Partial write sequence, after the fill:
- cpu_write=1, addr=0x1234_5664, wdata=0xAABB_CCDD, byte_en=0101.
- Result: rdata at 0x1234_5664 = 0x11BB_11DD; other words unchanged; dirty_out=0.
REQ-040 dirty_set=1 at index 3 -> dirty_out=1; a later fill to index 3 -> dirty_out=0, valid_out=1.
REQ-041 Simultaneous fill and cpu_write at the same index -> line equals fill_data exactly.
REQ-042 Mid-operation reset:
- Pulse reset_n low between clock edges after several fills.
- Result: every index reads valid_out=0, line_out=0.
- With CACHE_WAY_STORE_FWD_EN defined: fill shows hit=1 in the same cycle.
